sw_debounce: RTL

Input-conditioning stage between the board slide switches and the LED mode controller. Each switch bit is synchronised into the `clk` domain through a 2-flop synchroniser, then debounced by a per-bit stability counter. The block drives a clean, glitch-free `sw_db` bus that the LED controller uses as its mode select. It also emits one-cycle rise, fall and change strobes, so downstream logic can restart its timers on a mode change.

---
 rtl/board_pkg.sv | 17 +
 rtl/debounce_bit.sv | 60 ++++++
 rtl/sw_debounce.sv | 53 +++++
 3 files changed

// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch debouncer and the LED mode
// controller.
//   CLK_HZ          system clock frequency
//   DB_CYCLES_10MS  debounce window of 10 ms at CLK_HZ
//   SW_WIDTH        number of slide switches on the board
package board_pkg;

  localparam int unsigned CLK_HZ         = 125_000_000;
  localparam int unsigned DB_CYCLES_10MS = CLK_HZ / 100;
  localparam int unsigned SW_WIDTH       = 2;

  // Width of a counter that must reach db_cycles-1 and no further.
  function automatic int unsigned db_cnt_width(input int unsigned db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, accepted level and
// registered rise/fall strobes.
//   clk, rst_n  system clock, async active-low reset
//   sw_in       raw asynchronous switch level
//   sw_db       accepted (debounced) level
//   sw_rise     one-cycle pulse after an accepted 0->1
//   sw_fall     one-cycle pulse after an accepted 1->0
//   accept      high in the cycle before the strobes; lets the parent
//               register a combined change flag aligned with the strobes
module debounce_bit
  import board_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  localparam int unsigned      CW      = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          st;
  logic [CW-1:0] cnt;

  assign accept = (s2 != st) && (cnt == CNT_MAX);
  assign sw_db  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      st      <= 1'b0;
      cnt     <= '0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      s1      <= sw_in;
      s2      <= s1;
      sw_rise <= accept & s2;
      sw_fall <= accept & ~s2;
      // Any agreement between s2 and st discards partial credit.
      if (s2 == st) begin
        cnt <= '0;
      end else if (accept) begin
        st  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch bus for the LED mode controller.
//   clk, rst_n  system clock, async active-low reset
//   sw_in       raw asynchronous switch levels [WIDTH]
//   sw_db       debounced levels [WIDTH]
//   sw_rise     per-bit one-cycle pulse on accepted 0->1 [WIDTH]
//   sw_fall     per-bit one-cycle pulse on accepted 1->0 [WIDTH]
//   sw_changed  one-cycle pulse when any bit was accepted, aligned with strobes
module sw_debounce
  import board_pkg::*;
#(
  parameter int unsigned WIDTH     = SW_WIDTH,
  parameter int unsigned DB_CYCLES = DB_CYCLES_10MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("sw_debounce: DB_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_in  (sw_in[i]),
      .sw_db  (sw_db[i]),
      .sw_rise(sw_rise[i]),
      .sw_fall(sw_fall[i]),
      .accept (accept[i])
    );
  end

  // Registered from the pre-strobe accept terms so it lands in the same
  // cycle as sw_rise/sw_fall rather than one later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |accept;
    end
  end

endmodule
